// File: rtl/sram_core_arbiter_pkg.sv
// Shared constants and types for the sram core arbiter slice.
// Word-address/data widths match the sram_axi / sram_top core interface.
package sram_core_arbiter_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_BE_W   = 2;

  typedef enum logic {
    CMD_WR = 1'b0,
    CMD_RD = 1'b1
  } cmd_e;

  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_core_arbiter_if.sv
// Requester-side and sram_top-side command/read-data signals of the core arbiter.
// slave = arbiter view, master = requesters plus sram_top view.
interface sram_core_arbiter_if
  import sram_core_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W
);

  logic [NUM_REQ-1:0]          req_req;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_rd;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W/8-1:0] req_be;
  logic [NUM_REQ*DATA_W-1:0]   req_wr_data;
  logic [NUM_REQ-1:0]          req_rd_data_vld;
  logic [DATA_W-1:0]           req_rd_data;

  logic                        sram_req;
  logic                        sram_ready;
  logic                        sram_rd;
  logic [ADDR_W-1:0]           sram_addr;
  logic [DATA_W/8-1:0]         sram_be;
  logic [DATA_W-1:0]           sram_wr_data;
  logic                        sram_rd_data_vld;
  logic [DATA_W-1:0]           sram_rd_data;

  modport slave (
    input  req_req, req_rd, req_addr, req_be, req_wr_data,
    input  sram_ready, sram_rd_data_vld, sram_rd_data,
    output req_ready, req_rd_data_vld, req_rd_data,
    output sram_req, sram_rd, sram_addr, sram_be, sram_wr_data
  );

  modport master (
    output req_req, req_rd, req_addr, req_be, req_wr_data,
    output sram_ready, sram_rd_data_vld, sram_rd_data,
    input  req_ready, req_rd_data_vld, req_rd_data,
    input  sram_req, sram_rd, sram_addr, sram_be, sram_wr_data
  );

endinterface

// File: rtl/sram_core_arbiter_tag_fifo.sv
// sram_arb_tag_fifo: in-order FIFO of requester indices for outstanding reads.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sram_arb_tag_fifo
  import sram_core_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/sram_core_arbiter.sv
// Zero-latency arbiter sharing the sram_top core port between NUM_REQ requesters.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module sram_core_arbiter
  import sram_core_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_,
  sram_core_arbiter_if.slave  bus,
  output logic                arb_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   head;
  logic               any_elig;
  logic               accept;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  int unsigned        idx;

  // A full tag FIFO blocks reads even if a return pops it this same cycle.
  assign eligible = bus.req_req & ~(bus.req_rd & {NUM_REQ{fifo_full}});

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt      = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = k;
      if (!any_elig && eligible[IDX_W'(idx)]) begin
        any_elig = 1'b1;
        gnt      = IDX_W'(idx);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    gnt      = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_elig && eligible[IDX_W'(idx)]) begin
        any_elig = 1'b1;
        gnt      = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)     rr_ptr <= '0;
    else if (accept) rr_ptr <= IDX_W'(wrap_inc(int'(gnt), NUM_REQ));
  end
`endif

  assign bus.sram_req = reset_ & any_elig;
  assign accept       = bus.sram_req & bus.sram_ready;

  always_comb begin
    bus.req_ready      = '0;
    bus.sram_rd        = 1'b0;
    bus.sram_addr      = '0;
    bus.sram_be        = '0;
    bus.sram_wr_data   = '0;
    if (accept) bus.req_ready[gnt] = 1'b1;
    if (bus.sram_req) begin
      bus.sram_rd      = bus.req_rd[gnt];
      bus.sram_addr    = bus.req_addr[gnt*ADDR_W +: ADDR_W];
      bus.sram_be      = bus.req_be[gnt*BE_W +: BE_W];
      bus.sram_wr_data = bus.req_wr_data[gnt*DATA_W +: DATA_W];
    end
  end

  assign fifo_push = accept && (cmd_e'(bus.sram_rd) == CMD_RD);
  assign fifo_pop  = bus.sram_rd_data_vld & ~fifo_empty;

  sram_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_    (reset_),
    .push      (fifo_push),
    .push_data (gnt),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    bus.req_rd_data_vld = '0;
    if (reset_ && fifo_pop) bus.req_rd_data_vld[head] = 1'b1;
  end

  assign bus.req_rd_data = bus.sram_rd_data;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                                  arb_err <= 1'b0;
    else if (bus.sram_rd_data_vld && fifo_empty)  arb_err <= 1'b1;
  end

endmodule

// File: tb/tb_sram_core_arbiter.sv
// Self-checking bench for sram_core_arbiter against a queue-based reference model.
module tb_sram_core_arbiter;

  localparam int N  = 2;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset_;
  logic arb_err;

  sram_core_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_core_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .bus     (bus),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next-priority index, owner queue of outstanding reads, sticky error,
  // and the bench-side sram's queue of read addresses still owed a return.
  int              m_ptr;
  int              m_tags[$];
  bit              m_err;
  int              m_acc;
  logic [AW-1:0]   s_pend[$];

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v = N'(1) << i;
    return v;
  endfunction

  function automatic int m_grant();
    int start;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (bus.req_req[i] && !(bus.req_rd[i] && m_tags.size() == TD)) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_exp_ready();
    int g;
    g = m_grant();
    return (g >= 0 && bus.sram_ready) ? onehot(g) : '0;
  endfunction

  function automatic logic [N-1:0] m_exp_vld();
    if (bus.sram_rd_data_vld && m_tags.size() > 0) return onehot(m_tags[0]);
    return '0;
  endfunction

  task automatic model_clock();
    int g;
    bit acc;
    @(posedge clk);
    g   = m_grant();
    acc = (g >= 0) && bus.sram_ready && reset_;
    m_acc = acc ? g : -1;
    if (reset_) begin
      if (bus.sram_rd_data_vld) begin
        if (m_tags.size() > 0) void'(m_tags.pop_front());
        else                   m_err = 1'b1;
        if (s_pend.size() > 0) void'(s_pend.pop_front());
      end
      if (acc && bus.req_rd[g]) begin
        m_tags.push_back(g);
        s_pend.push_back(bus.req_addr[g*AW +: AW]);
      end
      if (acc) m_ptr = (g + 1) % N;
    end
    #1;
  endtask

  task automatic set_return(bit en);
    logic [AW-1:0] a;
    if (en && s_pend.size() > 0) begin
      a = s_pend[0];
      bus.sram_rd_data_vld = 1'b1;
      bus.sram_rd_data     = a[DW-1:0];
    end else begin
      bus.sram_rd_data_vld = 1'b0;
      bus.sram_rd_data     = DW'($urandom);
    end
  endtask

  task automatic clear_inputs();
    bus.req_req          = '0;
    bus.req_rd           = '0;
    bus.req_addr         = '0;
    bus.req_be           = '0;
    bus.req_wr_data      = '0;
    bus.sram_ready       = 1'b0;
    bus.sram_rd_data_vld = 1'b0;
    bus.sram_rd_data     = '0;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    m_ptr = 0;
    m_tags.delete();
    s_pend.delete();
    m_err = 1'b0;
    m_acc = -1;
    #1 reset_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    clear_inputs();
    bus.req_req          = 2'b11;
    bus.req_rd           = 2'b11;
    bus.sram_ready       = 1'b1;
    bus.sram_rd_data_vld = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.sram_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_sram_req: got %b expected 0", bus.sram_req);
    end
    n_tests++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready);
    end
    n_tests++;
    if (bus.req_rd_data_vld !== 2'b00) begin
      n_fail++; $display("FAIL reset_rd_vld: got %b expected 00", bus.req_rd_data_vld);
    end
    n_tests++;
    if (arb_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_arb_err: got %b expected 0", arb_err);
    end
    do_reset();
  endtask

  task automatic test_rr_fairness();
    int exp_g;
    do_reset();
    bus.req_req        = 2'b11;
    bus.req_rd         = 2'b11;
    bus.req_addr       = {18'h155, 18'h348};
    bus.sram_ready     = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_return(1'b1);
      @(negedge clk);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = c % 2;
`endif
      n_tests++;
      if (bus.req_ready !== onehot(exp_g)) begin
        n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.req_ready, onehot(exp_g));
      end
      n_tests++;
      if (bus.sram_addr !== ((exp_g == 1) ? 18'h155 : 18'h348)) begin
        n_fail++; $display("FAIL rr_addr c%0d: got %h expected %h", c, bus.sram_addr,
                           (exp_g == 1) ? 18'h155 : 18'h348);
      end
      n_tests++;
      if (bus.req_rd_data_vld !== m_exp_vld()) begin
        n_fail++; $display("FAIL rr_vld c%0d: got %b expected %b", c, bus.req_rd_data_vld, m_exp_vld());
      end
      model_clock();
    end
    clear_inputs();
  endtask

  task automatic test_steering();
    do_reset();
    bus.req_req    = 2'b11;
    bus.req_rd     = 2'b11;
    bus.req_addr   = {18'h3ff, 18'h000};
    bus.sram_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL steer_grant0: got %b expected 01", bus.req_ready);
    end
    model_clock();
    bus.req_req = 2'b10;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL steer_grant1: got %b expected 10", bus.req_ready);
    end
    model_clock();
    bus.req_req = 2'b00;
    set_return(1'b1);
    @(negedge clk);
    n_tests++;
    if (bus.req_rd_data_vld !== 2'b01 || bus.req_rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL steer_ret0: got vld %b data %h expected vld 01 data 0000",
                         bus.req_rd_data_vld, bus.req_rd_data);
    end
    model_clock();
    set_return(1'b1);
    @(negedge clk);
    n_tests++;
    if (bus.req_rd_data_vld !== 2'b10 || bus.req_rd_data !== 16'h03ff) begin
      n_fail++; $display("FAIL steer_ret1: got vld %b data %h expected vld 10 data 03ff",
                         bus.req_rd_data_vld, bus.req_rd_data);
    end
    model_clock();
    clear_inputs();
  endtask

  task automatic test_full();
    do_reset();
    bus.req_req    = 2'b01;
    bus.req_rd     = 2'b01;
    bus.sram_ready = 1'b1;
    for (int a = 0; a < TD; a++) begin
      bus.req_addr[0 +: AW] = AW'(a);
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 2'b01) begin
        n_fail++; $display("FAIL full_fill%0d: got %b expected 01", a, bus.req_ready);
      end
      model_clock();
    end
    bus.req_addr            = {18'h010, 18'h004};
    bus.req_wr_data[DW +: DW] = 16'hbeef;
    bus.req_be[BW +: BW]    = 2'b11;
    bus.req_req             = 2'b11;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 2'b10 || bus.sram_rd !== 1'b0 || bus.sram_addr !== 18'h010 ||
        bus.sram_wr_data !== 16'hbeef) begin
      n_fail++; $display("FAIL full_write: got rdy %b rd %b addr %h data %h expected 10 0 010 beef",
                         bus.req_ready, bus.sram_rd, bus.sram_addr, bus.sram_wr_data);
    end
    model_clock();
    bus.req_req = 2'b01;
    @(negedge clk);
    n_tests++;
    if (bus.sram_req !== 1'b0) begin
      n_fail++; $display("FAIL full_block: got sram_req %b expected 0", bus.sram_req);
    end
    model_clock();
    set_return(1'b1);
    @(negedge clk);
    n_tests++;
    if (bus.sram_req !== 1'b0 || bus.req_rd_data_vld !== 2'b01) begin
      n_fail++; $display("FAIL full_pop_block: got sram_req %b vld %b expected 0 01",
                         bus.sram_req, bus.req_rd_data_vld);
    end
    model_clock();
    set_return(1'b0);
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 2'b01 || bus.sram_addr !== 18'h004) begin
      n_fail++; $display("FAIL full_refill: got rdy %b addr %h expected 01 004",
                         bus.req_ready, bus.sram_addr);
    end
    model_clock();
    bus.req_req = 2'b00;
    for (int k = 0; k < TD; k++) begin
      set_return(1'b1);
      @(negedge clk);
      n_tests++;
      if (bus.req_rd_data_vld !== 2'b01) begin
        n_fail++; $display("FAIL full_drain%0d: got %b expected 01", k, bus.req_rd_data_vld);
      end
      model_clock();
    end
    clear_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    bus.sram_rd_data_vld = 1'b1;
    bus.sram_rd_data     = 16'h1234;
    @(negedge clk);
    n_tests++;
    if (bus.req_rd_data_vld !== 2'b00) begin
      n_fail++; $display("FAIL spur_vld: got %b expected 00", bus.req_rd_data_vld);
    end
    model_clock();
    bus.sram_rd_data_vld = 1'b0;
    repeat (3) model_clock();
    @(negedge clk);
    n_tests++;
    if (arb_err !== 1'b1) begin
      n_fail++; $display("FAIL spur_sticky: got %b expected 1", arb_err);
    end
    do_reset();
    @(negedge clk);
    n_tests++;
    if (arb_err !== 1'b0) begin
      n_fail++; $display("FAIL spur_clear: got %b expected 0", arb_err);
    end
    model_clock();
  endtask

  task automatic test_random();
    bit act[N];
    int g;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    logic [DW-1:0] ed;
    logic          er;
    do_reset();
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset();
        for (int i = 0; i < N; i++) act[i] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1'b1;
          bus.req_rd[i]                = 1'($urandom_range(0, 1));
          bus.req_addr[i*AW +: AW]     = AW'($urandom);
          bus.req_be[i*BW +: BW]       = BW'($urandom);
          bus.req_wr_data[i*DW +: DW]  = DW'($urandom);
        end
        bus.req_req[i] = act[i];
      end
      bus.sram_ready = ($urandom_range(0, 3) != 0);
      set_return($urandom_range(0, 1) == 1);
      @(negedge clk);
      g = m_grant();
      er = 1'b0; ea = '0; eb = '0; ed = '0;
      if (g >= 0) begin
        er = bus.req_rd[g];
        ea = bus.req_addr[g*AW +: AW];
        eb = bus.req_be[g*BW +: BW];
        ed = bus.req_wr_data[g*DW +: DW];
      end
      n_tests++;
      if (bus.sram_req !== (g >= 0) || bus.req_ready !== m_exp_ready()) begin
        n_fail++; $display("FAIL rand_grant c%0d: got req %b rdy %b expected %b %b",
                           c, bus.sram_req, bus.req_ready, (g >= 0), m_exp_ready());
      end
      n_tests++;
      if (bus.sram_rd !== er || bus.sram_addr !== ea || bus.sram_be !== eb ||
          bus.sram_wr_data !== ed) begin
        n_fail++; $display("FAIL rand_fields c%0d: got %b %h %b %h expected %b %h %b %h", c,
                           bus.sram_rd, bus.sram_addr, bus.sram_be, bus.sram_wr_data, er, ea, eb, ed);
      end
      n_tests++;
      if (bus.req_rd_data_vld !== m_exp_vld() ||
          (bus.sram_rd_data_vld && bus.req_rd_data !== bus.sram_rd_data)) begin
        n_fail++; $display("FAIL rand_return c%0d: got vld %b data %h expected vld %b data %h", c,
                           bus.req_rd_data_vld, bus.req_rd_data, m_exp_vld(), bus.sram_rd_data);
      end
      n_tests++;
      if (arb_err !== m_err) begin
        n_fail++; $display("FAIL rand_err c%0d: got %b expected %b", c, arb_err, m_err);
      end
      model_clock();
      for (int i = 0; i < N; i++) if (m_acc == i) act[i] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    m_ptr = 0;
    m_err = 1'b0;
    m_acc = -1;
    test_reset();
    test_rr_fairness();
    test_steering();
    test_full();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
